// File: rtl/dac_ctrl.sv
// dac_ctrl: I2S serializer between the FM synthesizer and the external codec.
// Produces MCLK, BCLK, LRCK and SDTI, latches one stereo pair per 64-bit
// frame and pulses `next` to the synthesizer when the pair has been taken.
// Every codec-facing output comes straight from a flip-flop that is loaded
// from the next-state decode, so the pins carry no combinational glitches
// and always agree with the counter state of the current cycle.
module dac_ctrl #(
  parameter int unsigned BCLK_HALF  = 8,  // clk cycles per BCLK half period (2..255)
  parameter int unsigned MCLK_SHIFT = 1   // MCLK = clk / 2^(MCLK_SHIFT+1)    (0..7)
) (
  input  logic        clk,
  input  logic        reset,     // synchronous, active low
  input  logic [15:0] sample_l,
  input  logic [15:0] sample_r,
  output logic        next,
  output logic        mclk,
  output logic        bclk,
  output logic        lrck,
  output logic        sdti
);

  // Divider sizing: div runs 0 .. 2*BCLK_HALF-1.
  localparam int unsigned DIV_W  = $clog2(2 * BCLK_HALF);
  localparam int unsigned MCNT_W = MCLK_SHIFT + 1;

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(2 * BCLK_HALF - 1);
  localparam logic [DIV_W-1:0]  BCLK_HI  = DIV_W'(BCLK_HALF);
  localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
  localparam logic [MCNT_W-1:0] MCNT_ONE = MCNT_W'(1);

  // Serial bit for slot position p of word h (I2S: one BCLK of delay after
  // the LRCK edge, 16 data bits MSB first, zero padding to 32 bits).
  function automatic logic slot_bit(input logic [4:0] p, input logic [15:0] h);
    logic [4:0] idx;
    logic       b;
    idx = 5'd16 - p;
    if ((p >= 5'd1) && (p <= 5'd16)) begin
      b = h[idx[3:0]];
    end else begin
      b = 1'b0;
    end
    return b;
  endfunction

  // --------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------
  logic [DIV_W-1:0]  div_q,     div_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [MCNT_W-1:0] mcnt_q,    mcnt_d;
  logic [15:0]       hold_l_q,  hold_l_d;
  logic [15:0]       hold_r_q,  hold_r_d;
  logic              next_q,    next_d;
  logic              mclk_q,    mclk_d;
  logic              bclk_q,    bclk_d;
  logic              lrck_q,    lrck_d;
  logic              sdti_q,    sdti_d;

  logic              div_wrap_s;
  logic              frame_end_s;
  logic [15:0]       word_s;

  // Counter advance and frame-end detection.
  always_comb begin
    div_wrap_s  = (div_q == DIV_LAST);
    frame_end_s = div_wrap_s && (bit_cnt_q == 6'd63);

    if (div_wrap_s) begin
      div_d     = '0;
      bit_cnt_d = bit_cnt_q + 6'd1;   // wraps 63 -> 0 by width
    end else begin
      div_d     = div_q + DIV_ONE;
      bit_cnt_d = bit_cnt_q;
    end

    // MCLK counter is free running and unrelated to the BCLK divider.
    mcnt_d = mcnt_q + MCNT_ONE;
  end

  // Pair latch and handshake: inputs are only looked at on the frame-end cycle.
  always_comb begin
    if (frame_end_s) begin
      hold_l_d = sample_l;
      hold_r_d = sample_r;
      next_d   = 1'b1;
    end else begin
      hold_l_d = hold_l_q;
      hold_r_d = hold_r_q;
      next_d   = 1'b0;
    end
  end

  // Output decode from the next counter/hold state, so the registered pins
  // line up with the counters with zero lag.
  always_comb begin
    bclk_d = (div_d >= BCLK_HI);
    lrck_d = bit_cnt_d[5];
    mclk_d = mcnt_d[MCLK_SHIFT];

    if (bit_cnt_d[5]) begin
      word_s = hold_r_d;
    end else begin
      word_s = hold_l_d;
    end

    sdti_d = slot_bit(bit_cnt_d[4:0], word_s);
  end

  // State and output registers; reset clears everything on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q     <= '0;
      bit_cnt_q <= 6'd0;
      mcnt_q    <= '0;
      hold_l_q  <= 16'd0;
      hold_r_q  <= 16'd0;
      next_q    <= 1'b0;
      mclk_q    <= 1'b0;
      bclk_q    <= 1'b0;
      lrck_q    <= 1'b0;
      sdti_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      mcnt_q    <= mcnt_d;
      hold_l_q  <= hold_l_d;
      hold_r_q  <= hold_r_d;
      next_q    <= next_d;
      mclk_q    <= mclk_d;
      bclk_q    <= bclk_d;
      lrck_q    <= lrck_d;
      sdti_q    <= sdti_d;
    end
  end

  assign next = next_q;
  assign mclk = mclk_q;
  assign bclk = bclk_q;
  assign lrck = lrck_q;
  assign sdti = sdti_q;

endmodule

// File: tb/tb_dac_ctrl.sv
// Directed bench for dac_ctrl. A default-parameter instance is checked for
// frame timing, clock ratios and serial data; a second instance with
// BCLK_HALF=2, MCLK_SHIFT=0 is checked for its clock ratios. Expected serial
// bits are pushed to a queue when a pair is latched and popped at each BCLK
// rising edge.
module tb_dac_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic        next, mclk, bclk, lrck, sdti;
  logic        next2, mclk2, bclk2, lrck2, sdti2;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;          // clk edges since reset release
  logic exp_q[$];         // expected sdti at each BCLK rising edge

  always #5 clk = ~clk;

  dac_ctrl dut (
    .clk(clk), .reset(reset), .sample_l(sample_l), .sample_r(sample_r),
    .next(next), .mclk(mclk), .bclk(bclk), .lrck(lrck), .sdti(sdti)
  );

  dac_ctrl #(.BCLK_HALF(2), .MCLK_SHIFT(0)) dut2 (
    .clk(clk), .reset(reset), .sample_l(sample_l), .sample_r(sample_r),
    .next(next2), .mclk(mclk2), .bclk(bclk2), .lrck(lrck2), .sdti(sdti2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s at cyc %0d: observed %0h expected %0h", tag, cyc, obs, expv);
    end
  endtask

  // Expected I2S bit stream for one frame carrying the pair (l, r).
  task automatic push_frame(input logic [15:0] l, input logic [15:0] r);
    logic [15:0] h;
    for (int s = 0; s < 2; s++) begin
      h = (s == 0) ? l : r;
      for (int p = 0; p < 32; p++) begin
        if (p >= 1 && p <= 16) exp_q.push_back(h[16 - p]);
        else                   exp_q.push_back(1'b0);
      end
    end
  endtask

  // One clock cycle: schedule the latch expectation, advance, then check.
  task automatic tick();
    logic rst_now;
    logic b;
    rst_now = reset;
    if (rst_now && (cyc % 1024 == 1023)) push_frame(sample_l, sample_r);
    @(posedge clk);
    #1;
    if (rst_now) cyc++;
    else         cyc = 0;

    if (!rst_now) begin
      check("rst_next", next, 0);
      check("rst_bclk", bclk, 0);
      check("rst_lrck", lrck, 0);
      check("rst_sdti", sdti, 0);
      check("rst_mclk", mclk, 0);
      check("rst_outs2", {next2, bclk2, lrck2, sdti2, mclk2}, 0);
    end else begin
      check("next",  next,  (cyc % 1024 == 0) ? 1 : 0);
      check("bclk",  bclk,  (cyc % 16 >= 8) ? 1 : 0);
      check("lrck",  lrck,  (cyc % 1024 >= 512) ? 1 : 0);
      check("mclk",  mclk,  (cyc / 2) % 2);
      check("next2", next2, (cyc % 256 == 0) ? 1 : 0);
      check("bclk2", bclk2, (cyc % 4 >= 2) ? 1 : 0);
      check("lrck2", lrck2, (cyc % 256 >= 128) ? 1 : 0);
      check("mclk2", mclk2, cyc % 2);
      if (cyc % 16 == 8) begin
        check("sb_nonempty", (exp_q.size() != 0) ? 1 : 0, 1);
        if (exp_q.size() != 0) begin
          b = exp_q.pop_front();
          check("sdti", sdti, b);
        end
      end
    end
  endtask

  initial begin
    // Reset with a pair already on the inputs; holds must still start at 0.
    reset    = 1'b0;
    sample_l = 16'hA5C3;
    sample_r = 16'h0001;
    repeat (3) tick();
    exp_q.delete();
    push_frame(16'h0000, 16'h0000);
    reset = 1'b1;

    // Frame 1: all zeros; its closing edge latches A5C3/0001.
    repeat (1024) tick();

    // Frame 2 carries A5C3/0001; mid-frame input changes are ignored here.
    repeat (100) tick();
    sample_l = 16'h1234;
    sample_r = 16'h8000;
    repeat (924) tick();

    // One cycle after the frame-end cycle: too late for this frame.
    sample_l = 16'hFFFF;
    repeat (1024) tick();

    // Frame 4 carries FFFF/8000; stop at bit_cnt = 20 and reset.
    repeat (20 * 16 + 3) tick();
    reset = 1'b0;
    tick();
    exp_q.delete();
    push_frame(16'h0000, 16'h0000);
    reset = 1'b1;

    // New frame timing from the release, zeros first, then FFFF/8000.
    repeat (1100) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
